// File: rtl/memory_access_if.sv
// Handshake and data bundle between the memory stage, its upstream, data memory and writeback.
// slave is the stage's view; master is the surrounding pipeline/memory view.
interface memory_access_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [31:0] in_alu_res;
  logic [31:0] in_reg_2;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_result;
  logic        out_fault;

  modport slave (
    input  in_valid, in_instruction, in_alu_res, in_reg_2,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_data,
    output in_ready, dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
    output out_valid, out_instruction, out_result, out_fault
  );

  modport master (
    output in_valid, in_instruction, in_alu_res, in_reg_2,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_data,
    input  in_ready, dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
    input  out_valid, out_instruction, out_result, out_fault
  );
endinterface

// File: rtl/memory_access.sv
// Memory stage: load/store with alignment checks, strobes and sign extension; one result pulse per beat.
// Latency 1 (non-mem/fault), 2+ (store), 3+ (load); in_ready low while a beat is in flight, no writeback backpressure.
module memory_access (
  input  logic           clock,
  input  logic           reset,
  memory_access_if.slave bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [31:0] lat_addr;

  logic [2:0]  f3;
  logic        is_load;
  logic        is_store;
  logic        width_ok;
  logic        legal;
  logic [3:0]  strb;
  logic [31:0] wdata;

  always_comb begin
    f3       = bus.in_instruction[14:12];
    is_load  = bus.in_instruction[6:0] == OP_LOAD;
    is_store = bus.in_instruction[6:0] == OP_STORE;
    width_ok = 1'b0;
    strb     = 4'b1111;
    wdata    = bus.in_reg_2;
    case (f3[1:0])
      2'b00: begin
        width_ok = 1'b1;
        strb     = 4'b0001 << bus.in_alu_res[1:0];
        wdata    = {4{bus.in_reg_2[7:0]}};
      end
      2'b01: begin
        width_ok = ~bus.in_alu_res[0];
        strb     = 4'b0011 << bus.in_alu_res[1:0];
        wdata    = {2{bus.in_reg_2[15:0]}};
      end
      2'b10:   width_ok = bus.in_alu_res[1:0] == 2'b00;
      default: width_ok = 1'b0;
    endcase
    // funct3[2] only names the unsigned byte/half loads; LWU-style 110 and all store variants with it are illegal.
    legal = width_ok && (!f3[2] || (is_load && f3[1:0] != 2'b10));
  end

  function automatic logic [31:0] load_extract(input logic [2:0] fn, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (fn)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      state               <= IDLE;
      lat_addr            <= '0;
      bus.in_ready        <= 1'b1;
      bus.dmem_req_valid  <= 1'b0;
      bus.dmem_addr       <= '0;
      bus.dmem_we         <= 1'b0;
      bus.dmem_wstrb      <= '0;
      bus.dmem_wdata      <= '0;
      bus.out_valid       <= 1'b0;
      bus.out_instruction <= '0;
      bus.out_result      <= '0;
      bus.out_fault       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          bus.in_ready        <= 1'b0;
          bus.out_instruction <= bus.in_instruction;
          lat_addr            <= bus.in_alu_res;
          if ((is_load || is_store) && legal) begin
            state              <= REQ;
            bus.dmem_req_valid <= 1'b1;
            bus.dmem_addr      <= {bus.in_alu_res[31:2], 2'b00};
            bus.dmem_we        <= is_store;
            bus.dmem_wstrb     <= is_store ? strb : 4'b0000;
            bus.dmem_wdata     <= is_store ? wdata : 32'd0;
          end else begin
            state          <= DONE;
            bus.out_valid  <= 1'b1;
            bus.out_result <= bus.in_alu_res;
            bus.out_fault  <= is_load || is_store;
          end
        end
        REQ: if (bus.dmem_req_ready) begin
          bus.dmem_req_valid <= 1'b0;
          if (bus.dmem_we) begin
            state          <= DONE;
            bus.out_valid  <= 1'b1;
            bus.out_result <= lat_addr;
            bus.out_fault  <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (bus.dmem_rsp_valid) begin
          state          <= DONE;
          bus.out_valid  <= 1'b1;
          bus.out_result <= load_extract(bus.out_instruction[14:12], lat_addr[1:0],
                                         bus.dmem_rsp_data);
          bus.out_fault  <= 1'b0;
        end
        DONE: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.out_fault <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed literal cases plus randomized beats against a queue-based reference model.
module tb_memory_access;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  memory_access_if bus();
  memory_access dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] result;
    logic        fault;
    logic [31:0] instr;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          is_mem;
    bit          fault;
    bit          we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] result;
  } model_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  bit   req_exp = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] fn);
    return {17'd0, fn, 5'd1, op};
  endfunction

  // Reference: access size/signedness from funct3, then plain shift/mask arithmetic on the word.
  function automatic model_t model(input logic [31:0] ins, input logic [31:0] alu,
                                   input logic [31:0] rs2, input logic [31:0] rsp);
    model_t m;
    int size, off;
    bit sgn, ld, st;
    logic [31:0] mask, v;
    ld = ins[6:0] == 7'b0000011;
    st = ins[6:0] == 7'b0100011;
    size = 0;
    sgn  = 1'b0;
    if (ld) begin
      case (ins[14:12])
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd4: size = 1;
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd5: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end
    if (st) begin
      case (ins[14:12])
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end
    off = int'(alu[1:0]);
    m.is_mem = ld || st;
    m.we     = st;
    m.result = alu;
    m.addr   = alu & 32'hFFFF_FFFC;
    m.strb   = 4'd0;
    m.wdata  = 32'd0;
    m.fault  = 1'b0;
    if (m.is_mem) begin
      if (size == 0) m.fault = 1'b1;
      else if ((off % size) != 0) m.fault = 1'b1;
    end
    if (m.is_mem && !m.fault) begin
      if (st) begin
        m.strb = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = rs2[8*(i % size) +: 8];
      end else begin
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
        v = (rsp >> (8*off)) & mask;
        if (sgn && v[8*size-1]) v = v | ~mask;
        m.result = v;
      end
    end
    return m;
  endfunction

  // Per-cycle compare against the expectation queue.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      if (bus.out_valid) begin
        if (q.size() == 0) chk("unexpected out_valid", bus.out_valid, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("out_result", bus.out_result, e.result);
          chk("out_fault", bus.out_fault, e.fault);
          chk("out_instruction", bus.out_instruction, e.instr);
          chk("out_valid cycle", cyc, e.cyc);
          chk("in_ready during out_valid", bus.in_ready, 0);
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        chk("out_valid late", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (bus.dmem_req_valid && !req_exp) chk("unexpected dmem_req_valid", bus.dmem_req_valid, 0);
    end
  end

  task automatic run_txn(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [31:0] rsp, input int rd, input int sd,
                         input bit lit, input logic [31:0] lit_res, input bit lit_fault);
    model_t m;
    exp_t   e;
    int     t, n;
    m = model(ins, alu, rs2, rsp);
    if (lit) begin
      chk("model pin result", m.result, lit_res);
      chk("model pin fault", m.fault, lit_fault);
    end
    chk("in_ready idle", bus.in_ready, 1);
    t       = cyc + 1;
    e.result = lit ? lit_res : m.result;
    e.fault  = lit ? lit_fault : m.fault;
    e.instr  = ins;
    e.cyc    = (!m.is_mem || m.fault) ? t : (m.we ? t + 1 + rd : t + 2 + rd + sd);
    q.push_back(e);
    req_exp = m.is_mem && !m.fault;
    bus.in_valid       = 1'b1;
    bus.in_instruction = ins;
    bus.in_alu_res     = alu;
    bus.in_reg_2       = rs2;
    bus.dmem_rsp_valid = 1'($urandom % 2);
    bus.dmem_rsp_data  = $urandom;
    @(negedge clock);
    bus.in_valid       = 1'b0;
    bus.in_instruction = $urandom;
    bus.in_alu_res     = $urandom;
    bus.in_reg_2       = $urandom;
    bus.dmem_rsp_valid = 1'b0;
    if (req_exp) begin
      for (int k = 0; k <= rd; k++) begin
        chk("dmem_req_valid", bus.dmem_req_valid, 1);
        chk("dmem_addr", bus.dmem_addr, m.addr);
        chk("dmem_we", bus.dmem_we, m.we);
        chk("dmem_wstrb", bus.dmem_wstrb, m.strb);
        if (m.we) chk("dmem_wdata", bus.dmem_wdata, m.wdata);
        bus.dmem_req_ready = (k == rd);
        bus.dmem_rsp_valid = 1'($urandom % 2);
        bus.dmem_rsp_data  = $urandom;
        @(negedge clock);
      end
      bus.dmem_req_ready = 1'b0;
      bus.dmem_rsp_valid = 1'b0;
      req_exp = 1'b0;
      if (!m.we) begin
        for (int k = 0; k <= sd; k++) begin
          chk("dmem_req_valid low in wait", bus.dmem_req_valid, 0);
          bus.dmem_req_ready = 1'($urandom % 2);
          bus.dmem_rsp_valid = (k == sd);
          bus.dmem_rsp_data  = (k == sd) ? rsp : $urandom;
          @(negedge clock);
        end
        bus.dmem_rsp_valid = 1'b0;
        bus.dmem_req_ready = 1'b0;
      end
    end
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (q.size() > 0) begin
      chk("out_valid timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
    $fatal(1);
  end

  initial begin
    model_t m;
    logic [6:0]  op;
    logic [2:0]  fn;
    logic [31:0] ins;
    bus.in_valid = 1'b0; bus.in_instruction = '0; bus.in_alu_res = '0; bus.in_reg_2 = '0;
    bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0; bus.dmem_rsp_data = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset dmem_req_valid", bus.dmem_req_valid, 0);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_fault", bus.out_fault, 0);
    chk("reset out_result", bus.out_result, 0);
    chk("reset dmem_addr", bus.dmem_addr, 0);
    chk("reset dmem_wstrb", bus.dmem_wstrb, 0);

    run_txn(mk(7'b0110011, 3'd0), 32'h0000_1234, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0000_1234, 1'b0);

    m = model(mk(7'b0100011, 3'd0), 32'h0000_1002, 32'hAABB_CCDD, 32'h0);
    chk("model pin SB strb", m.strb, 4'b0100);
    chk("model pin SB wdata", m.wdata, 32'hDDDD_DDDD);
    chk("model pin SB addr", m.addr, 32'h0000_1000);
    run_txn(mk(7'b0100011, 3'd0), 32'h0000_1002, 32'hAABB_CCDD, 32'h0, 2, 0, 1'b1, 32'h0000_1002, 1'b0);

    run_txn(mk(7'b0000011, 3'd1), 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0, 0, 1'b1, 32'hFFFF_8001, 1'b0);
    run_txn(mk(7'b0000011, 3'd5), 32'h0000_2002, 32'h0, 32'h8001_7FFF, 1, 2, 1'b1, 32'h0000_8001, 1'b0);
    run_txn(mk(7'b0000011, 3'd0), 32'h0000_3003, 32'h0, 32'h80FF_FFFF, 0, 1, 1'b1, 32'hFFFF_FF80, 1'b0);
    run_txn(mk(7'b0000011, 3'd2), 32'h0000_4002, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0000_4002, 1'b1);
    run_txn(mk(7'b0000011, 3'd7), 32'h0000_5000, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0000_5000, 1'b1);
    run_txn(mk(7'b0100011, 3'd3), 32'h0000_5004, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0000_5004, 1'b1);
    run_txn(mk(7'b0000011, 3'd2), 32'h0000_6004, 32'h0, 32'hCAFE_F00D, 3, 3, 1'b1, 32'hCAFE_F00D, 1'b0);

    // Reset while a load waits for its response; the late response must be dropped.
    chk("in_ready before reset test", bus.in_ready, 1);
    req_exp = 1'b1;
    bus.in_valid = 1'b1; bus.in_instruction = mk(7'b0000011, 3'd2); bus.in_alu_res = 32'h0000_7000;
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.dmem_req_ready = 1'b1;
    @(negedge clock);
    bus.dmem_req_ready = 1'b0;
    req_exp = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("mid-wait reset in_ready", bus.in_ready, 1);
    chk("mid-wait reset dmem_req_valid", bus.dmem_req_valid, 0);
    chk("mid-wait reset out_valid", bus.out_valid, 0);
    chk("mid-wait reset out_result", bus.out_result, 0);
    bus.dmem_rsp_valid = 1'b1;
    bus.dmem_rsp_data  = 32'h1234_5678;
    @(negedge clock);
    bus.dmem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late response ignored", bus.out_valid, 0);
      @(negedge clock);
    end

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: op = 7'b0000011;
        1: op = 7'b0100011;
        2: op = 7'b0110011;
        default: op = 7'($urandom);
      endcase
      fn  = 3'($urandom);
      ins = $urandom;
      ins[6:0]   = op;
      ins[14:12] = fn;
      run_txn(ins, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              1'b0, 32'h0, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
